chkmon_seq: RTL and testbench
=============================

Name: chkmon_seq

Overview:
- Synthesizable checkpoint-sequence monitor for the FPGA SoC harness.
- Watches a WIDTH-bit status bus (e.g. mprj_io[31:16]) and requires NUM_CHK expected values to appear in order, each held stable for STABLE_CYCLES, within TIMEOUT_CYCLES.
- Reports pass/fail on-chip, so LA/GPIO self-tests run on hardware with no simulator bench.

Parameters:
- WIDTH, 16: monitored bus width.
- NUM_CHK, 3: number of checkpoints, >=1.
- TIMEOUT_CYCLES, 250000: cycles allowed in SEEK before timeout fail, >=1.
- STABLE_CYCLES, 2: consecutive matching synced samples needed for a hit, >=1.
- SYNC_STAGES, 2: input synchroniser depth, >=2.

Ports:
- clock  in  1  sole clock, rising edge.
- resetb  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; begins a run from IDLE/PASS/FAIL.
- abort  in  1  forces IDLE, clears results.
- mon_in  in  WIDTH  asynchronous monitored bus.
- exp_vals  in  NUM_CHK*WIDTH  checkpoint i at bits [i*WIDTH +: WIDTH]; quasi-static during a run.
- busy  out  1  high in SEEK.
- hit  out  1  one-cycle pulse per checkpoint matched.
- chk_idx  out  $clog2(NUM_CHK+1)  index of checkpoint being sought / count matched.
- done  out  1  high in PASS or FAIL.
- pass  out  1  all checkpoints matched.
- fail_timeout  out  1  timeout occurred.
- fail_order  out  1  out-of-order checkpoint (optional feature only).
- elapsed  out  32  SEEK cycles elapsed, saturating at 2^32-1.

Behaviour:
- Reset: all outputs 0; state IDLE; synchroniser flops 0; counters 0.
- States: IDLE, SEEK, PASS, FAIL; all outputs registered.
- IDLE: start=1 -> SEEK next edge; chk_idx=0, elapsed=0, stable count=0, all flags cleared.
- PASS/FAIL: flags held; start=1 restarts exactly as from IDLE.
- SEEK: start ignored.
- abort=1 from any state -> IDLE next edge, flags cleared. abort takes priority over start.
- Sync: mon_in passes through SYNC_STAGES flops giving sync_val; no multi-bit coherence guarantee, which the stability filter covers.
- Stable count (SEEK only): increments when sync_val == exp_vals[chk_idx]; otherwise resets to 0.
- Hit: when the count reaches STABLE_CYCLES, hit pulses one cycle, chk_idx increments, count resets to 0. A held value therefore cannot match the next checkpoint until STABLE_CYCLES fresh samples, so identical consecutive checkpoints are allowed.
- Latency: hit rises SYNC_STAGES+STABLE_CYCLES edges after mon_in settles on the expected value (4 with defaults).
- Last checkpoint (chk_idx==NUM_CHK-1) hit -> PASS; pass=1, chk_idx=NUM_CHK.
- Timeout: elapsed increments every SEEK cycle. At elapsed==TIMEOUT_CYCLES-1 with no final hit that cycle -> FAIL, fail_timeout=1.
- Simultaneous final hit and timeout: PASS wins.
- Mid-run reset: immediate return to reset values.

Optional Feature:
- Macro: CHKMON_STRICT_ORDER_EN.
- Defined: in SEEK, a second stable counter tracks sync_val equal to any exp_vals[j] with j>chk_idx and not equal to exp_vals[chk_idx]. Reaching STABLE_CYCLES -> FAIL with fail_order=1.
- Order fail and timeout in the same cycle: fail_order wins, fail_timeout=0.
- Undefined: such values are ignored; fail_order tied 0.

Decomposition:
- chkmon_pkg: state enum (IDLE/SEEK/PASS/FAIL), ELAPSED_W=32 constant, idx-width helper function.
- Sub-module chkmon_sync: SYNC_STAGES synchroniser plus equality-stability counter (inputs value and target, output stable_hit). Instantiated once, and a second time under CHKMON_STRICT_ORDER_EN.

Test Plan:
- Happy path: exp=AB40,AB41,AB51; start; drive AB40, AB41, AB51 each for 10 cycles -> three hit pulses, chk_idx 0->1->2->3, pass=1, done=1, busy=0.
- Glitch filter: drive AB40 for 1 cycle, then 0000, then AB40 for 10 cycles -> exactly one hit, 4 edges after the stable value.
- Timeout: TIMEOUT_CYCLES=100; start, hold 0000 -> fail_timeout=1 at elapsed=99, pass=0, chk_idx=0.
- Race: final checkpoint stabilises on the timeout cycle -> pass=1, fail_timeout=0.
- Abort/restart: abort mid-SEEK at chk_idx=1 -> IDLE, all flags 0; restart, full sequence -> pass=1. Assert resetb mid-SEEK -> all outputs 0 immediately.
- Strict order (macro defined): after AB40, drive AB51 for 10 cycles -> fail_order=1, chk_idx=1. Macro undefined: same stimulus -> stays in SEEK until timeout.

Source files
------------

// File: rtl/chkmon_pkg.sv
// Shared types and helpers for the checkpoint-sequence monitor.
package chkmon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam int ELAPSED_W = 32;

  // Bits needed to hold any value 0..n (never less than one bit).
  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/chkmon_sync.sv
// Input synchroniser plus equality-stability counter.
// The synchronised sample matches when it equals any enabled target and does
// not equal the veto value; stable_hit fires on the sample that completes
// STABLE_CYCLES consecutive matches, and the run count restarts from zero.
module chkmon_sync
  import chkmon_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NT            = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic [WIDTH-1:0]    value,
  input  logic [NT*WIDTH-1:0] targets,
  input  logic [NT-1:0]       tgt_en,
  input  logic [WIDTH-1:0]    veto,
  input  logic                veto_en,
  input  logic                count_en,
  input  logic                clr,
  output logic                stable_hit
);

  localparam int CW = idx_w(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_val;
  logic             any_eq;
  logic             match;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Shift the asynchronous bus through the synchroniser chain.
  always_comb begin
    sync_d[0] = value;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  // Compare the synchronised sample against the enabled target set.
  always_comb begin
    any_eq = 1'b0;
    for (int k = 0; k < NT; k++) begin
      if (tgt_en[k] && (sync_val == targets[k*WIDTH +: WIDTH])) begin
        any_eq = 1'b1;
      end
    end
    match = any_eq && !(veto_en && (sync_val == veto));
  end

  assign stable_hit = count_en && match && (cnt_q == LAST_CNT);

  // Run length of consecutive matches; any break, clear or hit restarts it.
  always_comb begin
    if (!count_en || clr || !match || stable_hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser and counter registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/chkmon_seq.sv
// Checkpoint-sequence monitor: requires NUM_CHK expected values to appear on
// mon_in in order, each stable for STABLE_CYCLES synchronised samples, within
// TIMEOUT_CYCLES of SEEK. Results are reported on registered flags.
// Optional build macro CHKMON_STRICT_ORDER_EN: a stable later checkpoint seen
// before the current one fails the run with fail_order.
module chkmon_seq
  import chkmon_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_CHK        = 3,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int STABLE_CYCLES  = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         mon_in,
  input  logic [NUM_CHK*WIDTH-1:0] exp_vals,
  output logic                     busy,
  output logic                     hit,
  output logic [idx_w(NUM_CHK)-1:0] chk_idx,
  output logic                     done,
  output logic                     pass,
  output logic                     fail_timeout,
  output logic                     fail_order,
  output logic [ELAPSED_W-1:0]     elapsed
);

  localparam int IW = idx_w(NUM_CHK);
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_CHK - 1);
  localparam logic [ELAPSED_W-1:0] TO_LAST  = ELAPSED_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        chk_idx_q, chk_idx_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic                 busy_q, busy_d;
  logic                 hit_q, hit_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_timeout_q, fail_timeout_d;
  logic                 fail_order_q, fail_order_d;

  logic [WIDTH-1:0]     target;
  logic                 seek;
  logic                 prim_hit;
  logic                 order_hit;

  assign seek = (state_q == ST_SEEK);

  // Select the checkpoint value currently being sought.
  always_comb begin
    target = '0;
    for (int j = 0; j < NUM_CHK; j++) begin
      if (chk_idx_q == IW'(j)) begin
        target = exp_vals[j*WIDTH +: WIDTH];
      end
    end
  end

  chkmon_sync #(
    .WIDTH         (WIDTH),
    .NT            (1),
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync (
    .clock      (clock),
    .resetb     (resetb),
    .value      (mon_in),
    .targets    (target),
    .tgt_en     (1'b1),
    .veto       (target),
    .veto_en    (1'b0),
    .count_en   (seek),
    .clr        (1'b0),
    .stable_hit (prim_hit)
  );

`ifdef CHKMON_STRICT_ORDER_EN
  logic [NUM_CHK-1:0] later_en;

  // Enable only checkpoints beyond the one currently sought.
  always_comb begin
    later_en = '0;
    for (int j = 0; j < NUM_CHK; j++) begin
      later_en[j] = (IW'(j) > chk_idx_q);
    end
  end

  // Runs its own synchroniser copy; cleared whenever the sought index moves.
  chkmon_sync #(
    .WIDTH         (WIDTH),
    .NT            (NUM_CHK),
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_order (
    .clock      (clock),
    .resetb     (resetb),
    .value      (mon_in),
    .targets    (exp_vals),
    .tgt_en     (later_en),
    .veto       (target),
    .veto_en    (1'b1),
    .count_en   (seek),
    .clr        (prim_hit),
    .stable_hit (order_hit)
  );
`else
  assign order_hit = 1'b0;
`endif

  // Sequencer next state: abort first, then per-state run control.
  always_comb begin
    state_d        = state_q;
    chk_idx_d      = chk_idx_q;
    elapsed_d      = elapsed_q;
    busy_d         = busy_q;
    hit_d          = 1'b0;
    done_d         = done_q;
    pass_d         = pass_q;
    fail_timeout_d = fail_timeout_q;
    fail_order_d   = fail_order_q;
    if (abort) begin
      state_d        = ST_IDLE;
      chk_idx_d      = '0;
      elapsed_d      = '0;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      pass_d         = 1'b0;
      fail_timeout_d = 1'b0;
      fail_order_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SEEK: begin
          if (prim_hit) begin
            hit_d     = 1'b1;
            chk_idx_d = chk_idx_q + IW'(1);
          end
          // A final hit beats both failure causes; order beats timeout.
          if (prim_hit && (chk_idx_q == LAST_IDX)) begin
            state_d = ST_PASS;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (order_hit) begin
            state_d      = ST_FAIL;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            fail_order_d = 1'b1;
          end else if (elapsed_q == TO_LAST) begin
            state_d        = ST_FAIL;
            busy_d         = 1'b0;
            done_d         = 1'b1;
            fail_timeout_d = 1'b1;
          end else if (elapsed_q != '1) begin
            elapsed_d = elapsed_q + ELAPSED_W'(1);
          end
        end
        default: begin
          if (start) begin
            state_d        = ST_SEEK;
            chk_idx_d      = '0;
            elapsed_d      = '0;
            busy_d         = 1'b1;
            done_d         = 1'b0;
            pass_d         = 1'b0;
            fail_timeout_d = 1'b0;
            fail_order_d   = 1'b0;
          end
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q        <= ST_IDLE;
      chk_idx_q      <= '0;
      elapsed_q      <= '0;
      busy_q         <= 1'b0;
      hit_q          <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_timeout_q <= 1'b0;
      fail_order_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      chk_idx_q      <= chk_idx_d;
      elapsed_q      <= elapsed_d;
      busy_q         <= busy_d;
      hit_q          <= hit_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_timeout_q <= fail_timeout_d;
      fail_order_q   <= fail_order_d;
    end
  end

  assign busy         = busy_q;
  assign hit          = hit_q;
  assign chk_idx      = chk_idx_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_timeout = fail_timeout_q;
  assign fail_order   = fail_order_q;
  assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_chkmon_seq.sv
// Testbench for chkmon_seq: directed scenarios plus randomized traffic, all
// compared every cycle against a sequence-level reference model.
module tb_chkmon_seq;

  localparam int WIDTH   = 16;
  localparam int NUM_CHK = 3;
  localparam int TO      = 100;
  localparam int STABLE  = 2;
  localparam int SYNC    = 2;
  localparam int IW      = 2;
`ifdef CHKMON_STRICT_ORDER_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic                     clock;
  logic                     resetb;
  logic                     start;
  logic                     abort;
  logic [WIDTH-1:0]         mon_in;
  logic [NUM_CHK*WIDTH-1:0] exp_vals;
  logic                     busy;
  logic                     hit;
  logic [IW-1:0]            chk_idx;
  logic                     done;
  logic                     pass;
  logic                     fail_timeout;
  logic                     fail_order;
  logic [31:0]              elapsed;

  chkmon_seq #(
    .WIDTH          (WIDTH),
    .NUM_CHK        (NUM_CHK),
    .TIMEOUT_CYCLES (TO),
    .STABLE_CYCLES  (STABLE),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clock        (clock),
    .resetb       (resetb),
    .start        (start),
    .abort        (abort),
    .mon_in       (mon_in),
    .exp_vals     (exp_vals),
    .busy         (busy),
    .hit          (hit),
    .chk_idx      (chk_idx),
    .done         (done),
    .pass         (pass),
    .fail_timeout (fail_timeout),
    .fail_order   (fail_order),
    .elapsed      (elapsed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  int    tcount = 0;
  int    n_hits = 0;
  int    last_hit_t = -1;
  string phase = "reset";

  // Reference model: run status, checkpoint progress, run lengths of the
  // synchronised samples and a delay line standing in for the synchroniser.
  logic [WIDTH-1:0] m_pipe [$];
  bit     m_busy, m_hit, m_pass, m_fto, m_ford;
  int     m_idx, m_run, m_orun;
  longint m_el;

  function automatic logic [WIDTH-1:0] exp_at(input int i);
    return exp_vals[i*WIDTH +: WIDTH];
  endfunction

  task automatic model_clear_run();
    m_busy = 0; m_hit = 0; m_pass = 0; m_fto = 0; m_ford = 0;
    m_idx = 0; m_run = 0; m_orun = 0; m_el = 0;
  endtask

  task automatic model_reset();
    model_clear_run();
    m_pipe.delete();
    repeat (SYNC) m_pipe.push_back('0);
  endtask

  task automatic model_step(input bit st, input bit ab, input logic [WIDTH-1:0] mon);
    logic [WIDTH-1:0] sv;
    int  cur;
    bit  later;
    sv = m_pipe[$];
    m_pipe.push_front(mon);
    void'(m_pipe.pop_back());
    m_hit = 0;
    if (ab) begin
      model_clear_run();
    end else if (m_busy) begin
      cur   = m_idx;
      later = 0;
      if (sv == exp_at(cur)) m_run++; else m_run = 0;
      for (int j = cur + 1; j < NUM_CHK; j++) if (sv == exp_at(j)) later = 1;
      if (later && sv != exp_at(cur)) m_orun++; else m_orun = 0;
      if (m_run == STABLE) begin
        m_hit = 1; m_run = 0; m_orun = 0; m_idx++;
      end
      if (m_idx == NUM_CHK) begin
        m_busy = 0; m_pass = 1;
      end else if (STRICT && m_orun == STABLE) begin
        m_busy = 0; m_ford = 1;
      end else if (m_el == TO - 1) begin
        m_busy = 0; m_fto = 1;
      end else if (m_el < 64'hFFFF_FFFF) begin
        m_el++;
      end
    end else if (st) begin
      model_clear_run();
      m_busy = 1;
    end
  endtask

  function automatic logic [39:0] model_vec();
    return {m_busy, m_hit, IW'(m_idx), (m_pass | m_fto | m_ford),
            m_pass, m_fto, m_ford, 32'(m_el)};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {busy, hit, chk_idx, done, pass, fail_timeout, fail_order, elapsed};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    check(tag, {39'd0, obs}, {39'd0, exp_v});
  endtask

  task automatic tick();
    @(posedge clock);
    if (resetb) model_step(start, abort, mon_in);
    else model_reset();
    #1;
    tcount++;
    if (hit === 1'b1) begin
      n_hits++;
      last_hit_t = tcount;
    end
    check(phase, dut_vec(), model_vec());
  endtask

  task automatic drive(input logic [WIDTH-1:0] v, input int n);
    mon_in = v;
    repeat (n) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_hits = 0;
  endtask

  initial begin
    int t0;
    int dur;
    int unsigned pick;
    resetb   = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    mon_in   = '0;
    exp_vals = {16'hAB51, 16'hAB41, 16'hAB40};
    model_reset();
    #2 resetb = 1'b0;
    #1;
    check("reset_all0", dut_vec(), 40'd0);
    tick();
    tick();
    resetb = 1'b1;

    // Happy path
    phase = "happy";
    do_start();
    drive(16'hAB40, 10);
    drive(16'hAB41, 10);
    drive(16'hAB51, 10);
    check1("happy_pass", pass, 1'b1);
    check1("happy_done", done, 1'b1);
    check1("happy_busy", busy, 1'b0);
    check("happy_idx", 40'(chk_idx), 40'd3);
    check("happy_hits", 40'(n_hits), 40'd3);

    // Glitch filter, restart from PASS
    phase = "glitch";
    mon_in = '0;
    do_start();
    drive(16'hAB40, 1);
    drive(16'h0000, 3);
    t0 = tcount + 1;
    drive(16'hAB40, 10);
    check("glitch_hits", 40'(n_hits), 40'd1);
    check("glitch_latency", 40'(last_hit_t), 40'(t0 + 3));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("glitch_abort_all0", dut_vec(), 40'd0);

    // Timeout
    phase = "timeout";
    mon_in = '0;
    do_start();
    drive(16'h0000, TO);
    check1("to_flag", fail_timeout, 1'b1);
    check("to_elapsed", 40'(elapsed), 40'd99);
    check1("to_pass", pass, 1'b0);
    check("to_idx", 40'(chk_idx), 40'd0);

    // Final hit lands on the timeout cycle
    phase = "race";
    do_start();
    drive(16'hAB40, 10);
    drive(16'hAB41, 10);
    drive(16'h0000, 76);
    drive(16'hAB51, 10);
    check1("race_pass", pass, 1'b1);
    check1("race_to", fail_timeout, 1'b0);

    // Abort mid-run then full restart
    phase = "abort";
    mon_in = '0;
    do_start();
    drive(16'hAB40, 10);
    check("abort_idx1", 40'(chk_idx), 40'd1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_all0", dut_vec(), 40'd0);
    mon_in = '0;
    do_start();
    drive(16'hAB40, 10);
    drive(16'hAB41, 10);
    drive(16'hAB51, 10);
    check1("restart_pass", pass, 1'b1);

    // Later checkpoint seen out of order
    phase = "order";
    mon_in = '0;
    do_start();
    drive(16'hAB40, 10);
    drive(16'hAB51, 10);
`ifdef CHKMON_STRICT_ORDER_EN
    check1("order_fail", fail_order, 1'b1);
    check("order_idx", 40'(chk_idx), 40'd1);
    check1("order_to", fail_timeout, 1'b0);
`else
    check1("order_busy", busy, 1'b1);
    check1("order_flag", fail_order, 1'b0);
    drive(16'hAB51, 80);
    check1("order_to", fail_timeout, 1'b1);
`endif

    // Randomized traffic
    phase = "random";
    for (int seg = 0; seg < 400; seg++) begin
      if (!m_busy && $urandom_range(0, 5) == 0) begin
        for (int k = 0; k < NUM_CHK; k++) begin
          exp_vals[k*WIDTH +: WIDTH] = 16'hAB40 + 16'($urandom_range(0, 3));
        end
      end
      pick = $urandom_range(0, 4);
      if (pick < 3) mon_in = exp_at(int'(pick));
      else if (pick == 3) mon_in = '0;
      else mon_in = 16'($urandom);
      dur = $urandom_range(1, 5);
      for (int c = 0; c < dur; c++) begin
        start = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 59) == 0);
        tick();
      end
    end
    start = 1'b0;
    abort = 1'b0;
    exp_vals = {16'hAB51, 16'hAB41, 16'hAB40};

    // Reset asserted in the middle of a run
    phase = "midreset";
    tick();
    mon_in = '0;
    do_start();
    drive(16'hAB40, 10);
    check1("mid_busy", busy, 1'b1);
    resetb = 1'b0;
    model_reset();
    #1;
    check("midrst_all0", dut_vec(), 40'd0);
    tick();
    tick();
    resetb = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
